// File: rtl/enemy_wave_ctrl_if.sv
// Signal bundle between the enemy wave controller and the enemy slot array.
// The master modport is the controller side; the slave modport is the slot array / game logic.
interface enemy_wave_ctrl_if #(
    parameter int N_ENEMY  = 8,
    parameter int MAX_WAVE = 7
);
    logic                              start;
    logic                              gameover;
    logic [N_ENEMY-1:0]                killed_all;
    logic [N_ENEMY-1:0]                spawned_all;
    logic [N_ENEMY-1:0]                spawn;
    logic                              clear;
    logic                              playing;
    logic [$clog2(MAX_WAVE+1)-1:0]     wave;
    logic [$clog2(N_ENEMY+1)-1:0]      alive_cnt;

    modport master (
        input  start, gameover, killed_all, spawned_all,
        output spawn, clear, playing, wave, alive_cnt
    );

    modport slave (
        output start, gameover, killed_all, spawned_all,
        input  spawn, clear, playing, wave, alive_cnt
    );
endinterface

// File: rtl/enemy_wave_ctrl.sv
// Enemy wave controller: game FSM, round-robin slot spawner with cooldown, kill tracking.
// Define WAVE_SCALING_EN to enable wave progression, cooldown scaling and the wave-based slot cap.
module enemy_wave_ctrl #(
    parameter int N_ENEMY        = 8,
    parameter int COOLDOWN       = 9_999_999,
    parameter int COOLDOWN_STEP  = 1_000_000,
    parameter int COOLDOWN_MIN   = 2_000_000,
    parameter int KILLS_PER_WAVE = 10,
    parameter int MAX_WAVE       = 7
) (
    input  logic               clk,
    input  logic               reset_n,
    enemy_wave_ctrl_if.master  bus
);
    localparam int PTR_W  = $clog2(N_ENEMY);
    localparam int CNT_W  = $clog2(N_ENEMY + 1);
    localparam int WAVE_W = $clog2(MAX_WAVE + 1);
    localparam int CD_W   = $clog2(COOLDOWN + 1);

    typedef enum logic [1:0] {S_OVER, S_CLEAR, S_GAME} state_t;

    state_t             r_state, w_state_nxt;
    logic               w_clear, w_playing;
    logic [N_ENEMY-1:0] r_free;
    logic [CNT_W-1:0]   r_alive;
    logic [PTR_W-1:0]   r_ptr;
    logic [CD_W-1:0]    r_cd;
    logic               r_hold_vld;
    logic [PTR_W-1:0]   r_hold_idx;

    logic               w_sel_found;
    logic [PTR_W-1:0]   w_sel_idx;
    logic [PTR_W-1:0]   w_spawn_idx;
    logic               w_spawn_vld;
    logic [N_ENEMY-1:0] w_spawn;
    logic               w_ack;
    logic [N_ENEMY-1:0] w_ack_mask;
    logic [N_ENEMY-1:0] w_kill;
    logic [CNT_W-1:0]   w_kill_n;
    logic               w_cap_ok;
    logic [CD_W-1:0]    w_cd_load;
    logic [CD_W-1:0]    w_cd_init;
    logic [WAVE_W-1:0]  w_wave;

    function automatic logic [CNT_W-1:0] f_popcnt(input logic [N_ENEMY-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < N_ENEMY; i++) c = c + CNT_W'(v[i]);
        return c;
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_OVER;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_clear     = 1'b0;
        w_playing   = 1'b0;
        case (r_state)
            S_OVER:  if (bus.start) w_state_nxt = S_CLEAR;
            S_CLEAR: begin
                w_clear     = 1'b1;
                w_state_nxt = S_GAME;
            end
            S_GAME: begin
                w_playing = 1'b1;
                if (bus.gameover) w_state_nxt = S_OVER;
            end
            default: w_state_nxt = S_OVER;
        endcase
    end

    // First free slot at or after the round-robin pointer, wrapping.
    always_comb begin
        logic [PTR_W:0] v_pos;
        w_sel_found = 1'b0;
        w_sel_idx   = '0;
        v_pos       = '0;
        for (int i = 0; i < N_ENEMY; i++) begin
            v_pos = {1'b0, r_ptr} + (PTR_W+1)'(i);
            if (v_pos >= (PTR_W+1)'(N_ENEMY)) v_pos = v_pos - (PTR_W+1)'(N_ENEMY);
            if (!w_sel_found && r_free[v_pos[PTR_W-1:0]]) begin
                w_sel_found = 1'b1;
                w_sel_idx   = v_pos[PTR_W-1:0];
            end
        end
    end

    // A pending request is latched so the one-hot stays stable until acknowledged.
    assign w_spawn_idx = r_hold_vld ? r_hold_idx : w_sel_idx;
    assign w_spawn_vld = w_playing &&
                         (r_hold_vld || ((r_cd == '0) && w_sel_found && w_cap_ok));
    assign w_spawn     = w_spawn_vld ? (N_ENEMY'(1) << w_spawn_idx) : '0;
    assign w_ack       = w_spawn_vld && (|(bus.spawned_all & w_spawn));
    assign w_ack_mask  = w_ack ? w_spawn : '0;
    assign w_kill      = bus.killed_all & ~r_free & ~w_ack_mask;
    assign w_kill_n    = f_popcnt(w_kill);

`ifdef WAVE_SCALING_EN
    localparam int KC_W = $clog2(KILLS_PER_WAVE + N_ENEMY + 1);

    logic [WAVE_W-1:0] r_wave, w_wave_nxt;
    logic [KC_W-1:0]   r_kill_cnt, w_kc_sum, w_kc_nxt;

    // max(COOLDOWN - w*COOLDOWN_STEP, COOLDOWN_MIN) without unsigned underflow.
    function automatic logic [CD_W-1:0] f_cooldown(input logic [WAVE_W-1:0] w);
        logic [63:0] v_red, v_cd;
        v_red = 64'(w) * 64'(COOLDOWN_STEP);
        if (v_red >= 64'(COOLDOWN)) begin
            v_cd = 64'(COOLDOWN_MIN);
        end else begin
            v_cd = 64'(COOLDOWN) - v_red;
            if (v_cd < 64'(COOLDOWN_MIN)) v_cd = 64'(COOLDOWN_MIN);
        end
        return v_cd[CD_W-1:0];
    endfunction

    always_comb begin
        w_kc_sum   = r_kill_cnt + KC_W'(w_kill_n);
        w_kc_nxt   = w_kc_sum;
        w_wave_nxt = r_wave;
        if (w_kc_sum >= KC_W'(KILLS_PER_WAVE)) begin
            w_kc_nxt = w_kc_sum - KC_W'(KILLS_PER_WAVE);
            if (r_wave != WAVE_W'(MAX_WAVE)) w_wave_nxt = r_wave + WAVE_W'(1);
        end
        if (int'(r_wave) + 2 < N_ENEMY) w_cap_ok = int'(r_alive) < int'(r_wave) + 2;
        else                            w_cap_ok = int'(r_alive) < N_ENEMY;
        w_cd_load = f_cooldown(w_wave_nxt);
        w_cd_init = f_cooldown('0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wave     <= '0;
            r_kill_cnt <= '0;
        end else if (r_state == S_CLEAR) begin
            r_wave     <= '0;
            r_kill_cnt <= '0;
        end else if (r_state == S_GAME && !bus.gameover) begin
            r_wave     <= w_wave_nxt;
            r_kill_cnt <= w_kc_nxt;
        end
    end

    assign w_wave = r_wave;
`else
    localparam int unused_cfg = COOLDOWN_STEP + COOLDOWN_MIN + KILLS_PER_WAVE;

    assign w_cap_ok  = int'(r_alive) < N_ENEMY;
    assign w_cd_load = CD_W'(COOLDOWN);
    assign w_cd_init = CD_W'(COOLDOWN);
    assign w_wave    = '0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_free     <= '1;
            r_alive    <= '0;
            r_ptr      <= '0;
            r_cd       <= '0;
            r_hold_vld <= 1'b0;
            r_hold_idx <= '0;
        end else begin
            case (r_state)
                S_CLEAR: begin
                    r_free     <= '1;
                    r_alive    <= '0;
                    r_cd       <= w_cd_init;
                    r_hold_vld <= 1'b0;
                end
                S_GAME: begin
                    if (bus.gameover) begin
                        r_hold_vld <= 1'b0;
                    end else begin
                        r_free     <= (r_free | w_kill) & ~w_ack_mask;
                        r_alive    <= r_alive + CNT_W'(w_ack) - w_kill_n;
                        r_hold_vld <= w_spawn_vld && !w_ack;
                        r_hold_idx <= w_spawn_idx;
                        if (w_ack) begin
                            r_cd <= w_cd_load;
                            if (w_spawn_idx == PTR_W'(N_ENEMY - 1)) r_ptr <= '0;
                            else                                    r_ptr <= w_spawn_idx + PTR_W'(1);
                        end else if (r_cd != '0) begin
                            r_cd <= r_cd - CD_W'(1);
                        end
                    end
                end
                default: r_hold_vld <= 1'b0;
            endcase
        end
    end

    assign bus.spawn     = w_spawn;
    assign bus.clear     = w_clear;
    assign bus.playing   = w_playing;
    assign bus.wave      = w_wave;
    assign bus.alive_cnt = r_alive;

endmodule

// File: doc/enemy_wave_ctrl.md
ENEMY_WAVE_CTRL -- requirements
Module: enemy_wave_ctrl

Interface
REQ-001 The block SHALL have parameter N_ENEMY, default 8, meaning number of enemy slots (2..32).
REQ-002 The block SHALL have parameter COOLDOWN, default 9_999_999, meaning wave-0 spawn cooldown in clk ticks.
REQ-003 The block SHALL have parameter COOLDOWN_STEP, default 1_000_000, meaning cooldown reduction per wave.
REQ-004 The block SHALL have parameter COOLDOWN_MIN, default 2_000_000, meaning cooldown floor.
REQ-005 The block SHALL have parameter KILLS_PER_WAVE, default 10, meaning kills needed to advance one wave.
REQ-006 The block SHALL have parameter MAX_WAVE, default 7, meaning saturating wave limit.
REQ-007 The block SHALL have port clk  in  1  meaning the single clock; all flops on its rising edge.
REQ-008 The block SHALL have port reset_n  in  1  meaning asynchronous, active-low reset.
REQ-009 The block SHALL have port start  in  1  meaning a request to begin a game, sampled in S_OVER.
REQ-010 The block SHALL have port gameover  in  1  meaning end the current game.
REQ-011 The block SHALL have port killed_all  in  N_ENEMY  meaning per-slot kill pulses; any subset may assert in one cycle.
REQ-012 The block SHALL have port spawned_all  in  N_ENEMY  meaning per-slot spawn acknowledge.
REQ-013 The block SHALL have port spawn  out  N_ENEMY  meaning one-hot spawn request, or zero.
REQ-014 The block SHALL have port clear  out  1  meaning a one-cycle pulse that resets all slots.
REQ-015 The block SHALL have port playing  out  1  meaning high in S_GAME.
REQ-016 The block SHALL have port wave  out  $clog2(MAX_WAVE+1)  meaning the current wave.
REQ-017 The block SHALL have port alive_cnt  out  $clog2(N_ENEMY+1)  meaning the number of occupied slots.

Function
REQ-018 FSM states SHALL be S_OVER, S_CLEAR and S_GAME; transitions SHALL be S_OVER->S_CLEAR on start, S_CLEAR->S_GAME unconditionally after 1 cycle, and S_GAME->S_OVER on gameover.
REQ-019 In S_CLEAR the block SHALL assert clear, set all free-mask bits, zero alive_cnt, wave and kill count, and load the cooldown counter with cooldown(0).
REQ-020 cooldown(w) SHALL equal max(COOLDOWN - w*COOLDOWN_STEP, COOLDOWN_MIN), computed without underflow.
REQ-021 The cooldown counter SHALL decrement once per cycle in S_GAME, saturating at 0.
REQ-022 cap SHALL equal min(N_ENEMY, wave+2).
REQ-023 spawn SHALL be nonzero only when all of the following hold: S_GAME, cooldown==0, free mask nonzero, alive_cnt<cap.
REQ-024 spawn SHALL select the first free slot at or after the round-robin pointer, wrapping modulo N_ENEMY.
REQ-025 A nonzero spawn SHALL be held stable until spawned_all&spawn is nonzero (acknowledge).
REQ-026 On acknowledge the block SHALL, on the next edge, clear that free bit, increment alive_cnt, set the pointer to index+1 mod N_ENEMY, and reload the cooldown with cooldown(wave) as updated that same edge.
REQ-027 spawned_all bits not matching spawn SHALL be ignored.
REQ-028 In S_GAME, killed_all bits on occupied slots SHALL set the free bit and decrement alive_cnt by their popcount; kills on free slots SHALL be ignored.
REQ-029 An acknowledge and kills in the same cycle SHALL both apply, with alive_cnt changing by the net amount; a same-cycle kill of the slot being acknowledged SHALL be ignored.
REQ-030 The kill count SHALL add the counted kills; on reaching KILLS_PER_WAVE it SHALL subtract KILLS_PER_WAVE (remainder kept) and increment wave, which saturates at MAX_WAVE.
REQ-031 gameover SHALL take priority; spawn and playing SHALL be 0 from the next cycle, and wave and alive_cnt SHALL hold until the next S_CLEAR.

Reset
REQ-032 reset_n low SHALL immediately force S_OVER, spawn=0, clear=0, playing=0, wave=0, alive_cnt=0, kill count=0, pointer=0, cooldown=0, and free mask all ones.
REQ-033 Reset deassertion mid-game SHALL leave the block in S_OVER awaiting start.

Configuration
REQ-034 With WAVE_SCALING_EN defined, wave, cooldown scaling and cap SHALL behave per REQ-020, REQ-022 and REQ-030.
REQ-035 Without WAVE_SCALING_EN, wave SHALL be constant 0, the cooldown SHALL always be COOLDOWN, cap SHALL be N_ENEMY, and no kill-count logic SHALL be built.

Verification
(Parameters: N_ENEMY=4, COOLDOWN=10, COOLDOWN_STEP=3, COOLDOWN_MIN=4, KILLS_PER_WAVE=2, MAX_WAVE=3, WAVE_SCALING_EN on.)
REQ-036 Start pulse -> clear high exactly 1 cycle; spawn=0001 after 10 S_GAME cycles; ack -> alive_cnt=1; spawn=0010 10 cycles later; after that ack spawn stays 0 (cap=2).
REQ-037 killed_all=0011 in one cycle -> alive_cnt=0, wave=1; next spawn 0100 (pointer) after cooldown reload of 7 cycles.
REQ-038 Ack of slot 3 plus killed_all=0001 in the same cycle -> alive_cnt net unchanged; next spawn=0001 (wrap).
REQ-039 gameover while spawn=0100 and unacked -> spawn=0 and playing=0 next cycle; a later start re-clears with wave=0.
REQ-040 reset_n low mid-game with no clk edge -> all outputs at reset values immediately.
REQ-041 WAVE_SCALING_EN off, 5 kills -> wave stays 0, cooldown 10, up to 4 concurrent spawns.
